// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned N x N -> 2N shift-add multiplier controller driving a shared external adder.
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_seq_ctrl #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   op_a,
    input  logic [N-1:0]   op_b,
    output logic [N-1:0]   add_a,
    output logic [N-1:0]   add_b,
    output logic           add_cin,
    input  logic [N-1:0]   add_sum,
    input  logic           add_cout,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;
    logic             step;

`ifdef MUL_EARLY_EXIT_EN
    logic [N-1:0]     rem_mask;
    // Selects the cnt_q low bits of lo that still hold unprocessed multiplier bits.
    assign rem_mask = ~({N{1'b1}} << cnt_q);
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        step      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    hi_d    = '0;
                    lo_d    = op_b;
                    cnt_d   = CW'(N);
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a = hi_q;
                add_b = lo_q[0] ? mcand_q : '0;
`ifdef MUL_EARLY_EXIT_EN
                if ((lo_q & rem_mask) == '0) begin
                    product_d = {hi_q, lo_q} >> cnt_q;
                    state_d   = DONE;
                end else begin
                    step = 1'b1;
                end
`else
                step = 1'b1;
`endif
                if (step) begin
                    hi_d  = {add_cout, add_sum[N-1:1]};
                    lo_d  = {add_sum[0], lo_q[N-1:1]};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        product_d = {hi_d, lo_d};
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule
